// File: rtl/display_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and helpers for the multiplexed 7-segment scan driver.
//   scan_state_e : scan FSM states (IDLE, BLANK, DRIVE)
//   BLANK_CODE   : digit code the downstream decoder renders as all-off
//   MAX_DIGITS   : widest digit count the helper functions support
//   onehot()     : digit index -> one-hot digit enable (MAX_DIGITS wide)
//   lz_mask()    : packed BCD value -> per-digit leading-zero blank flags
// -----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         MAX_DIGITS = 16;

    function automatic logic [MAX_DIGITS-1:0] onehot(input int idx);
        logic [MAX_DIGITS-1:0] res;
        res = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            res[i] = (idx == i);
        end
        return res;
    endfunction

    // Walk from the most significant digit downwards; a digit is blanked while
    // every digit from the top down to it is zero. Digit 0 always shows.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] val,
        input int                      n
    );
        logic [MAX_DIGITS-1:0] res;
        logic                  zero_run;
        res      = '0;
        zero_run = 1'b1;
        for (int i = MAX_DIGITS-1; i >= 1; i--) begin
            if (i < n) begin
                zero_run = zero_run && (val[4*i +: 4] == 4'h0);
                res[i]   = zero_run;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/display_scan_driver_scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Slot counter for the scan driver. Counts 0..SCAN_DIV-1 and wraps; the top
// holds it at 0 through clr while the display is dark.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear (counter forced to 0 next cycle)
//   blank_end  : counter is on the last dead-time cycle of the slot
//   slot_end   : counter is on the last cycle of the slot
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic blank_end,
    output logic slot_end
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign blank_end = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    assign slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || slot_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_driver.sv
// -----------------------------------------------------------------------------
// display_scan_driver
// Time-multiplexed scan driver for a multi-digit 7-segment display. Feeds one
// digit at a time to seven_segment_decoder with a one-hot digit enable and a
// dead-time gap at the start of every slot. New values arrive via valid/ready
// into a pending buffer and are committed to the shadow register only at frame
// boundaries (or straight away while idle), so a frame never tears.
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : 1 = scan, 0 = dark
//   load_valid   : load_data valid
//   load_data    : packed BCD, nibble i = digit i
//   load_ready   : pending buffer free
//   digit_code   : code for the decoder (BLANK_CODE = dark)
//   digit_sel    : one-hot digit enable, all-zero = off
//   frame_start  : one-cycle pulse on the first blank cycle of digit 0
// -----------------------------------------------------------------------------
module display_scan_driver
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_start
);

    localparam int                  IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int                  VAL_W    = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_e          state_q, state_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [VAL_W-1:0]     shadow_q, shadow_d;
    logic [VAL_W-1:0]     pend_data_q, pend_data_d;
    logic                 pend_vld_q, pend_vld_d;
    logic                 load_ready_q, load_ready_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic [3:0]           digit_code_q, digit_code_d;
    logic                 frame_start_q, frame_start_d;

    logic                 blank_end;
    logic                 slot_end;
    logic                 prescale_clr;
    logic                 boundary;
    logic                 commit;
    logic [4*MAX_DIGITS-1:0] shadow_ext;
    logic [NUM_DIGITS-1:0] lz_flags;
    logic [NUM_DIGITS-1:0] sel_onehot;

    // The slot counter only runs while scanning.
    assign prescale_clr = !enable || (state_q == IDLE);

    scan_prescaler #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .clr       (prescale_clr),
        .blank_end (blank_end),
        .slot_end  (slot_end)
    );

    // Next state, digit index and frame-boundary detection.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        boundary = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            index_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    index_d  = '0;
                    boundary = 1'b1;
                end
                BLANK: begin
                    if (blank_end) begin
                        state_d = DRIVE;
                    end
                end
                DRIVE: begin
                    if (slot_end) begin
                        state_d = BLANK;
                        if (index_q == LAST_IDX) begin
                            index_d  = '0;
                            boundary = 1'b1;
                        end else begin
                            index_d = index_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    index_d = '0;
                end
            endcase
        end
    end

    // Pending/shadow buffering. Commit uses the registered pending flag, so a
    // load accepted on a boundary cycle waits for the following boundary.
    always_comb begin
        commit      = pend_vld_q && (boundary || (state_q == IDLE));
        shadow_d    = shadow_q;
        pend_data_d = pend_data_q;
        pend_vld_d  = pend_vld_q;
        if (commit) begin
            shadow_d   = pend_data_q;
            pend_vld_d = 1'b0;
        end
        if (load_valid && load_ready_q) begin
            pend_data_d = load_data;
            pend_vld_d  = 1'b1;
        end
        load_ready_d = !pend_vld_d;
    end

    // Output values are derived from the next state so the registered outputs
    // line up with the state register. Shadow only changes on entry to BLANK
    // or IDLE, so the current shadow is always the one being displayed.
    always_comb begin
        shadow_ext                = '0;
        shadow_ext[VAL_W-1:0]     = shadow_q;
        lz_flags                  = NUM_DIGITS'(lz_mask(shadow_ext, NUM_DIGITS));
        sel_onehot                = NUM_DIGITS'(onehot(int'(index_d)));

        digit_sel_d   = '0;
        digit_code_d  = BLANK_CODE;
        frame_start_d = boundary;
        if (state_d == DRIVE) begin
            digit_sel_d = sel_onehot;
            if ((LZ_BLANK != 0) && lz_flags[index_d]) begin
                digit_code_d = BLANK_CODE;
            end else begin
                digit_code_d = shadow_q[4*int'(index_d) +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            index_q       <= '0;
            shadow_q      <= '0;
            pend_data_q   <= '0;
            pend_vld_q    <= 1'b0;
            load_ready_q  <= 1'b1;
            digit_sel_q   <= '0;
            digit_code_q  <= BLANK_CODE;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            shadow_q      <= shadow_d;
            pend_data_q   <= pend_data_d;
            pend_vld_q    <= pend_vld_d;
            load_ready_q  <= load_ready_d;
            digit_sel_q   <= digit_sel_d;
            digit_code_q  <= digit_code_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign digit_sel   = digit_sel_q;
    assign digit_code  = digit_code_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_display_scan_driver
// Drives two instances (leading-zero blanking on and off) with directed and
// randomized load/enable/reset activity and compares every output every cycle
// against a behavioural model built from slot/frame arithmetic.
// -----------------------------------------------------------------------------
module tb_display_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load_valid;
    logic [15:0] load_data;

    logic        load_ready,   load_ready_n;
    logic [3:0]  digit_code,   digit_code_n;
    logic [3:0]  digit_sel,    digit_sel_n;
    logic        frame_start,  frame_start_n;

    display_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .LZ_BLANK(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .digit_code(digit_code),
        .digit_sel(digit_sel), .frame_start(frame_start)
    );

    display_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC), .LZ_BLANK(0)
    ) dut_nolz (
        .clk(clk), .rst(rst), .enable(enable), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready_n), .digit_code(digit_code_n),
        .digit_sel(digit_sel_n), .frame_start(frame_start_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_on: display scanning; m_tick: cycles since the current scan run began.
    bit          m_on;
    int          m_tick;
    bit          m_pend_v;
    logic [15:0] m_pend;
    logic [15:0] m_shadow;
    bit          m_fs;

    function automatic logic [3:0] exp_code(input logic [15:0] sh, input int dig, input bit lz);
        logic [15:0] upper;
        upper = sh >> (4 * dig);
        if (lz && dig > 0 && upper == 16'h0) return 4'hF;
        return upper[3:0];
    endfunction

    task automatic model_reset();
        m_on = 0; m_tick = 0; m_pend_v = 0; m_pend = '0; m_shadow = '0; m_fs = 0;
    endtask

    task automatic model_step();
        bit boundary, commit, ready_before;
        boundary     = enable && (!m_on || ((m_tick + 1) % FRAME == 0));
        commit       = m_pend_v && (boundary || !m_on);
        ready_before = !m_pend_v;
        if (commit) begin
            m_shadow = m_pend;
            m_pend_v = 0;
        end
        if (load_valid && ready_before) begin
            m_pend   = load_data;
            m_pend_v = 1;
        end
        if (!enable) begin
            m_on = 0; m_tick = 0;
        end else if (!m_on) begin
            m_on = 1; m_tick = 0;
        end else begin
            m_tick++;
        end
        m_fs = boundary;
    endtask

    task automatic compare();
        logic [3:0] e_sel, e_code, e_code_n;
        int pos, dig;
        e_sel = '0; e_code = 4'hF; e_code_n = 4'hF;
        if (m_on) begin
            pos = m_tick % SD;
            dig = (m_tick / SD) % ND;
            if (pos >= BC) begin
                e_sel    = 4'(1 << dig);
                e_code   = exp_code(m_shadow, dig, 1'b1);
                e_code_n = exp_code(m_shadow, dig, 1'b0);
            end
        end
        check_val("digit_sel",        32'(digit_sel),     32'(e_sel));
        check_val("digit_code",       32'(digit_code),    32'(e_code));
        check_val("frame_start",      32'(frame_start),   32'(m_fs));
        check_val("load_ready",       32'(load_ready),    32'(!m_pend_v));
        check_val("nolz_digit_sel",   32'(digit_sel_n),   32'(e_sel));
        check_val("nolz_digit_code",  32'(digit_code_n),  32'(e_code_n));
        check_val("nolz_frame_start", 32'(frame_start_n), 32'(m_fs));
        check_val("nolz_load_ready",  32'(load_ready_n),  32'(!m_pend_v));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic run(input int n);
        repeat (n) tick_cycle();
    endtask

    task automatic load(input logic [15:0] val);
        load_valid = 1'b1;
        load_data  = val;
        tick_cycle();
        load_valid = 1'b0;
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must go dark at once.
    task automatic reset_pulse(input int pre);
        #(pre);
        rst = 1'b1;
        #1;
        check_val("rst_digit_sel",   32'(digit_sel),    32'h0);
        check_val("rst_digit_code",  32'(digit_code),   32'hF);
        check_val("rst_frame_start", 32'(frame_start),  32'h0);
        check_val("rst_load_ready",  32'(load_ready),   32'h1);
        check_val("rst_nolz_ready",  32'(load_ready_n), 32'h1);
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    // Advance until the model says digit d is being driven (bounded).
    task automatic seek_drive(input int d);
        bit found;
        found = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (m_on && (m_tick % SD) >= BC && ((m_tick / SD) % ND) == d) begin
                found = 1;
                break;
            end
            tick_cycle();
        end
        check_val("seek_drive", 32'(found), 32'h1);
    endtask

    // Advance until the next rising edge is a frame boundary (bounded).
    task automatic seek_boundary();
        bit found;
        found = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (m_on && ((m_tick + 1) % FRAME) == 0) begin
                found = 1;
                break;
            end
            tick_cycle();
        end
        check_val("seek_boundary", 32'(found), 32'h1);
    endtask

    function automatic logic [15:0] rand_bcdish();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < ND; i++) begin
            if ($urandom_range(0, 2) != 0) v[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin
        rst = 1'b1; enable = 1'b0; load_valid = 1'b0; load_data = '0;
        model_reset();
        reset_pulse(0);

        // 1: load while idle, then scan
        load(16'h1234);
        run(3);
        enable = 1'b1;
        run(2 * FRAME + 5);

        // 2: load mid-frame; held valid while not ready has no effect
        seek_drive(1);
        load(16'h5678);
        load_valid = 1'b1; load_data = 16'h9999;
        run(4);
        load_valid = 1'b0;
        run(2 * FRAME);

        // 3: leading-zero blanking
        load(16'h0070);
        run(2 * FRAME + 4);
        load(16'h0000);
        run(2 * FRAME + 4);

        // 4: enable dropped during digit-2 drive, then restored
        load(16'h4321);
        run(2 * FRAME);
        seek_drive(2);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(FRAME + 8);

        // 5: reset during drive with a pending load
        seek_drive(1);
        load(16'h8765);
        seek_drive(3);
        reset_pulse(2);
        run(2 * FRAME);

        // 6: load accepted on the boundary cycle commits one frame later
        load(16'hDEF0);
        run(2 * FRAME);
        seek_boundary();
        load(16'h9ABC);
        run(2 * FRAME + 4);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            load_valid = ($urandom_range(0, 7) == 0);
            load_data  = rand_bcdish();
            if ($urandom_range(0, 119) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
            tick_cycle();
            if ($urandom_range(0, 399) == 0) reset_pulse(2);
        end
        load_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
